brent_kung_pipe: RTL and testbench
==================================

BRENT_KUNG_PIPE -- requirements
Module: brent_kung_pipe

Interface
REQ-001 SHALL have parameter N, default 32, operand width (N >= 2, power of two).
REQ-002 SHALL have parameter OVF_EN, default 1, enables the signed-overflow output logic (0: Ovf tied low).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-007 SHALL have port A  input  N  operand A.
REQ-008 SHALL have port B  input  N  operand B.
REQ-009 SHALL have port Cin  input  1  carry-in, add mode only.
REQ-010 SHALL have port Sub  input  1  0 = add, 1 = subtract.
REQ-011 SHALL have port out_valid  output  1  result beat present.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-013 SHALL have port Sum  output  N+1  result; Sum[N] = carry-out.
REQ-014 SHALL have port Ovf  output  1  signed two's-complement overflow of Sum[N-1:0].

Function
REQ-015 Add mode SHALL produce Sum = A + B + Cin, zero-extended to N+1 bits.
REQ-016 Sub mode SHALL produce Sum = A + ~B + 1, Cin ignored; Sum[N] = 1 means no borrow (A >= B unsigned).
REQ-017 Carries SHALL come from a Brent-Kung prefix tree (log2 N up-sweep levels, log2 N - 1 down-sweep levels) over g = a&b', p = a^b', with b' = B or ~B and the carry-in fed as the level-0 generate.
REQ-018 Ovf SHALL equal carry into bit N-1 XOR carry out of bit N-1, for both modes.
REQ-019 Pipeline SHALL be exactly 3 register stages: S1 = operands + p/g; S2 = up-sweep complete; S3 = down-sweep complete + Sum/Ovf registered.
REQ-020 A beat SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-021 With no back-pressure, the result of a beat accepted on edge t SHALL be on Sum/Ovf with out_valid = 1 after edge t+2.
REQ-022 Throughput SHALL be one beat per cycle while out_ready = 1.
REQ-023 Each stage k SHALL hold a valid bit; stage k SHALL load when !valid_k || ready_(k+1); ready after S3 is out_ready.
REQ-024 in_ready SHALL be !valid_S1 || ready_S2 (combinational, no dependence on in_valid).
REQ-025 With out_ready held low, the block SHALL accept exactly 3 beats, then drop in_ready; no beat lost, duplicated or reordered.
REQ-026 Sum, Ovf and out_valid SHALL remain stable while out_valid && !out_ready.
REQ-027 On a cycle with both acceptance and output consumption, both SHALL take effect on the same edge.
REQ-028 Stage data registers SHALL load only when the stage loads; a bubble SHALL not alter held data.

Reset
REQ-029 While rst = 1 on a rising edge, all stage valid bits SHALL clear; out_valid = 0, Sum = 0, Ovf = 0 after that edge.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-031 Reset mid-operation SHALL discard every in-flight beat; no result of a pre-reset beat SHALL appear afterward.
REQ-032 A beat presented during a reset cycle SHALL not be accepted.

Verification
REQ-033 N=32, add, A=FFFFFFFF, B=00000001, Cin=0 -> Sum=1_00000000, Ovf=0, out_valid after edge t+2.
REQ-034 N=32, add, A=7FFFFFFF, B=00000001, Cin=0 -> Sum=0_80000000, Ovf=1; sub, A=5, B=7 -> Sum=0_FFFFFFFE, Ovf=0.
REQ-035 N=32, out_ready=0, 5 consecutive beats offered -> first 3 accepted, in_ready=0 after third; release out_ready -> the 3 results, then the remaining 2, in order.
REQ-036 Reset pulse one cycle after 2 beats accepted -> out_valid=0 next cycle and no result of those 2 beats ever appears.
REQ-037 N=8, OVF_EN=1: exhaustive {Sub, Cin, B, A} (2^18 beats) streamed with random out_ready -> every Sum/Ovf matches the reference model, in order.
REQ-038 N=64, 10^5 random beats at full throughput -> one result per cycle after 3-cycle fill, all matching the model.

Source files
------------

// File: rtl/brent_kung_pipe.sv
// Three-stage pipelined Brent-Kung adder/subtractor with valid/ready flow control.
// S1 holds propagate/generate, S2 the up-swept tree, S3 the final Sum/Ovf.

module brent_kung_pipe #(
  parameter int N      = 32,
  parameter bit OVF_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         Sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   Sum,
  output logic         Ovf
);

  localparam int            LG  = $clog2(N);
  localparam logic [N-1:0]  ONE = {{(N-1){1'b0}}, 1'b1};

  // Up-sweep level l: node i absorbs node i-2^(l-1) when i+1 is a multiple of 2^l.
  function automatic logic [N-1:0] up_mask(input int l);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++)
      if (((i + 1) % (1 << l)) == 0) m = m | (ONE << i);
    return m;
  endfunction

  // Down-sweep level l: nodes halfway between up-sweep nodes pick up the full prefix.
  function automatic logic [N-1:0] dn_mask(input int l);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++)
      if ((((i + 1) % (1 << l)) == (1 << (l - 1))) && (i >= (1 << l))) m = m | (ONE << i);
    return m;
  endfunction

  logic         v1, v2, v3;
  logic         r1, r2, r3;
  logic [N-1:0] p1, g1, p2, gu2, pu2;
  logic         c1, c2;

  logic [N-1:0] bx, p0, g0;
  logic         c0;
  logic [N-1:0] gu, pu, gd;
  logic [N:0]   sum_c;
  logic         ovf_c;

  // A stage may load when empty or when its successor takes its contents.
  assign r3        = !v3 || out_ready;
  assign r2        = !v2 || r3;
  assign r1        = !v1 || r2;
  assign in_ready  = r1;
  assign out_valid = v3;

  // NOTE: combinational blocks assign every output first, so no latch is inferred.
  always_comb begin
    bx    = Sub ? ~B : B;
    c0    = Sub | Cin;
    p0    = A ^ bx;
    g0    = A & bx;
    g0[0] = g0[0] | (p0[0] & c0);
  end

  always_comb begin
    gu = g1;
    pu = p1;
    for (int l = 1; l <= LG; l++) begin
      gu = gu | (up_mask(l) & pu & (gu << (1 << (l - 1))));
      pu = pu & (~up_mask(l) | (pu << (1 << (l - 1))));
    end
  end

  // Each down-sweep node is touched once, so its up-swept group propagate is still current.
  always_comb begin
    gd = gu2;
    for (int l = LG - 1; l >= 1; l--)
      gd = gd | (dn_mask(l) & pu2 & (gd << (1 << (l - 1))));
    sum_c = {gd[N-1], p2 ^ {gd[N-2:0], c2}};
    ovf_c = OVF_EN ? (gd[N-1] ^ gd[N-2]) : 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      Sum <= '0;
      Ovf <= 1'b0;
    end else begin
      if (r1) v1 <= in_valid;
      if (r2) v2 <= v1;
      if (r3) v3 <= v2;
      if (r3 && v2) begin
        Sum <= sum_c;
        Ovf <= ovf_c;
      end
    end
  end

  // NOTE: datapath registers carry no reset; the valid bits alone decide whether they matter.
  always_ff @(posedge clk) begin
    if (r1 && in_valid) begin
      p1 <= p0;
      g1 <= g0;
      c1 <= c0;
    end
    if (r2 && v1) begin
      p2  <= p1;
      gu2 <= gu;
      pu2 <= pu;
      c2  <= c1;
    end
  end

endmodule

// File: tb/tb_brent_kung_pipe.sv
// Self-checking bench: four widths driven in lockstep, directed vectors, stall/reset
// sequences, and random streams scored against an arithmetic reference model.

module tb_brent_kung_pipe;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
  } beat_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [32:0] sum;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;

  logic        ir8, ir16, ir32, ir64;
  logic        ov8, ov16, ov32, ov64;
  logic        f8, f16, f32, f64;
  logic [8:0]  s8;
  logic [16:0] s16;
  logic [32:0] s32;
  logic [64:0] s64;

  int    errors = 0;
  int    checks = 0;
  int    n_out  = 0;
  beat_t q[$];
  logic        hold_pend = 1'b0;
  logic [32:0] hold_s32;
  logic        hold_f32;

  always #5 clk = ~clk;

  brent_kung_pipe #(.N(8), .OVF_EN(1'b1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8), .A(a[7:0]), .B(b[7:0]),
    .Cin(cin), .Sub(sub), .out_valid(ov8), .out_ready(out_ready), .Sum(s8), .Ovf(f8));
  brent_kung_pipe #(.N(16), .OVF_EN(1'b0)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16), .A(a[15:0]), .B(b[15:0]),
    .Cin(cin), .Sub(sub), .out_valid(ov16), .out_ready(out_ready), .Sum(s16), .Ovf(f16));
  brent_kung_pipe #(.N(32), .OVF_EN(1'b1)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32), .A(a[31:0]), .B(b[31:0]),
    .Cin(cin), .Sub(sub), .out_valid(ov32), .out_ready(out_ready), .Sum(s32), .Ovf(f32));
  brent_kung_pipe #(.N(64), .OVF_EN(1'b1)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir64), .A(a), .B(b),
    .Cin(cin), .Sub(sub), .out_valid(ov64), .out_ready(out_ready), .Sum(s64), .Ovf(f64));

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, {64'b0, act}, {64'b0, exp});
  endtask

  // Reference: plain n-bit arithmetic on A + (B or ~B) + carry.
  function automatic logic [64:0] ref_sum(input int n, input beat_t t);
    logic [65:0] m, x, y, s;
    m = (66'd1 << n) - 66'd1;
    x = {2'b0, t.a} & m;
    y = (t.sub ? ~{2'b0, t.b} : {2'b0, t.b}) & m;
    s = x + y + {65'd0, t.sub | t.cin};
    s = s & ((m << 1) | 66'd1);
    return s[64:0];
  endfunction

  // Signed overflow: equal operand signs that differ from the result sign.
  function automatic logic ref_ovf(input int n, input beat_t t);
    logic [65:0] m, x, y, s;
    m = (66'd1 << n) - 66'd1;
    x = {2'b0, t.a} & m;
    y = (t.sub ? ~{2'b0, t.b} : {2'b0, t.b}) & m;
    s = x + y + {65'd0, t.sub | t.cin};
    return (x[n-1] == y[n-1]) && (s[n-1] != x[n-1]);
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {63{1'b1}}};
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Scoreboard: beats enter in acceptance order, results must leave in the same order.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold_pend <= 1'b0;
    end else begin
      check("in_ready_lockstep", {62'b0, ir8, ir16, ir64}, {62'b0, ir32, ir32, ir32});
      check("out_valid_lockstep", {62'b0, ov8, ov16, ov64}, {62'b0, ov32, ov32, ov32});
      if (hold_pend) begin
        check_bit("stall_out_valid", ov32, 1'b1);
        check("stall_sum", {32'b0, s32}, {32'b0, hold_s32});
        check_bit("stall_ovf", f32, hold_f32);
      end
      if (ov32 && out_ready) begin
        check_bit("result_expected", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          check("sum8", {56'b0, s8}, ref_sum(8, q[0]));
          check_bit("ovf8", f8, ref_ovf(8, q[0]));
          check("sum16", {48'b0, s16}, ref_sum(16, q[0]));
          check_bit("ovf16_disabled", f16, 1'b0);
          check("sum32", {32'b0, s32}, ref_sum(32, q[0]));
          check_bit("ovf32", f32, ref_ovf(32, q[0]));
          check("sum64", s64, ref_sum(64, q[0]));
          check_bit("ovf64", f64, ref_ovf(64, q[0]));
          void'(q.pop_front());
          n_out <= n_out + 1;
        end
      end
      if (in_valid && ir32) q.push_back('{a, b, cin, sub});
      hold_pend <= ov32 && !out_ready;
      hold_s32  <= s32;
      hold_f32  <= f32;
    end
  end

  task automatic one_beat(input int idx, input vec_t v);
    @(posedge clk); #1;
    a = {32'h0, v.a}; b = {32'h0, v.b}; cin = v.cin; sub = v.sub;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check_bit($sformatf("dir%0d_in_ready", idx), ir32, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_bit($sformatf("dir%0d_valid_t", idx), ov32, 1'b0);
    @(negedge clk);
    check_bit($sformatf("dir%0d_valid_t1", idx), ov32, 1'b0);
    @(negedge clk);
    check_bit($sformatf("dir%0d_valid_t2", idx), ov32, 1'b1);
    check($sformatf("dir%0d_sum", idx), {32'b0, s32}, {32'b0, v.sum});
    check_bit($sformatf("dir%0d_ovf", idx), f32, v.ovf);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
    check_bit("drain_complete", q.size() == 0, 1'b1);
  endtask

  initial begin
    vec_t  vecs[11];
    beat_t bp[5];
    int    idx;
    int    n0;

    vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33'h1_0000_0000, 1'b0};
    vecs[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33'h0_8000_0000, 1'b1};
    vecs[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 33'h0_FFFF_FFFE, 1'b0};
    vecs[3]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 33'h0_0000_0001, 1'b0};
    vecs[4]  = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 33'h1_0000_0002, 1'b0};
    vecs[5]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 33'h1_7FFF_FFFF, 1'b1};
    vecs[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 33'h1_FFFF_FFFF, 1'b0};
    vecs[7]  = '{32'h0000_0003, 32'h0000_0003, 1'b1, 1'b1, 33'h1_0000_0000, 1'b0};
    vecs[8]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 33'h1_0000_0000, 1'b1};
    vecs[9]  = '{32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, 33'h0_2143_6588, 1'b0};
    vecs[10] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 33'h1_0000_0000, 1'b0};

    // Reset with a beat offered: nothing may be accepted.
    rst = 1'b1; in_valid = 1'b1; a = 64'h1; b = 64'h2; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_bit("reset_out_valid", ov32, 1'b0);
    check("reset_sum", {32'b0, s32}, 65'd0);
    check_bit("reset_ovf", f32, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_bit("ready_after_reset", ir32, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_bit("no_beat_from_reset", ov32, 1'b0);
    end

    for (int i = 0; i < 11; i++) one_beat(i, vecs[i]);
    drain();

    // Back-pressure: exactly three beats fit, then release and collect all five in order.
    for (int i = 0; i < 5; i++) bp[i] = '{rnd64(), rnd64(), 1'($urandom_range(1)), 1'($urandom_range(1))};
    idx = 0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      a = bp[idx].a; b = bp[idx].b; cin = bp[idx].cin; sub = bp[idx].sub; in_valid = 1'b1;
      @(negedge clk);
      check_bit($sformatf("stall_in_ready_c%0d", c), ir32, c < 3);
      if (ir32) idx++;
      @(posedge clk); #1;
    end
    check("stall_accepted", 65'(idx), 65'd3);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 5; c++) begin
      a = bp[idx].a; b = bp[idx].b; cin = bp[idx].cin; sub = bp[idx].sub; in_valid = 1'b1;
      @(negedge clk);
      if (ir32) idx++;
      @(posedge clk); #1;
    end
    check("stall_all_accepted", 65'(idx), 65'd5);
    drain();

    // Reset one cycle after two beats are taken: neither result may ever appear.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; a = rnd64(); b = rnd64();
    @(posedge clk); #1;
    a = rnd64(); b = rnd64();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_bit("midreset_out_valid", ov32, 1'b0);
    check("midreset_sum", {32'b0, s32}, 65'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_bit("midreset_no_result", ov32, 1'b0);
    end

    // Random stream with random back-pressure.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      in_valid  = $urandom_range(3) != 0;
      a         = rnd64();
      b         = rnd64();
      cin       = 1'($urandom_range(1));
      sub       = 1'($urandom_range(1));
      out_ready = $urandom_range(2) != 0;
    end
    drain();

    // Full throughput: one beat per cycle in, one result per cycle out after the fill.
    n0 = n_out;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; out_ready = 1'b1;
      a = rnd64(); b = rnd64();
      cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
      @(negedge clk);
      check_bit("tput_in_ready", ir32, 1'b1);
      check_bit("tput_out_valid", ov32, c >= 3);
    end
    drain();
    check("tput_result_count", 65'(n_out - n0), 65'd2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
